// File: rtl/mmcm_drp_ctrl.sv
// Reprograms MMCM CLKOUT0 integer divide over DRP (read-modify-write of ClkReg1/ClkReg2).
// Define MMCM_DRP_VERIFY_EN to read both registers back before the MMCM is released.
module mmcm_drp_ctrl #(
    parameter int unsigned LOCK_TIMEOUT = 1000000,
    parameter int unsigned DRP_TIMEOUT  = 64,
    parameter logic [6:0]  REG1_ADDR    = 7'h08,
    parameter logic [6:0]  REG2_ADDR    = 7'h09
) (
    input  logic        clk_10mhz,
    input  logic        rst,
    input  logic        req,
    input  logic [6:0]  divide,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [6:0]  drp_daddr,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    output logic        mmcm_rst,
    input  logic        mmcm_locked
);

    localparam int unsigned DrpW  = $clog2(DRP_TIMEOUT + 1);
    localparam int unsigned LockW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [DrpW-1:0]  DrpLast  = DrpW'(DRP_TIMEOUT - 1);
    localparam logic [DrpW-1:0]  DrpMax   = DrpW'(DRP_TIMEOUT);
    localparam logic [LockW-1:0] LockLast = LockW'(LOCK_TIMEOUT - 1);
    localparam logic [LockW-1:0] LockMax  = LockW'(LOCK_TIMEOUT);

    typedef enum logic [3:0] {
        StIdle,
        StRstOn,
        StRd1,
        StWr1,
        StRd2,
        StWr2,
`ifdef MMCM_DRP_VERIFY_EN
        StVrf1,
        StVrf2,
`endif
        StRstOff,
        StWaitLock
    } state_t;

    state_t           state;
    logic             pending;
    logic [DrpW-1:0]  drp_tmr;
    logic [LockW-1:0] lock_tmr;
    logic [5:0]       high_q;
    logic [5:0]       low_q;
    logic             edge_q;
    logic             nocnt_q;

    logic        div_ok;
    logic [5:0]  low_val;
    logic        ack;
    logic        drp_tmo;
    logic [15:0] wr1_data;
    logic [15:0] wr2_data;

    // True value of divide - high is below 64 for every legal divide, so 6-bit math is exact.
    assign low_val  = divide[5:0] - divide[6:1];
    assign div_ok   = (divide != 7'd0) && (divide != 7'h7f);
    assign ack      = pending && drp_drdy;
    assign drp_tmo  = pending && !drp_drdy && (drp_tmr == DrpLast);
    assign wr1_data = {drp_do[15:12], high_q, low_q};
    assign wr2_data = {drp_do[15:8], edge_q, nocnt_q, drp_do[5:0]};

`ifdef MMCM_DRP_VERIFY_EN
    logic [15:0] wr1_q;
    logic [15:0] wr2_q;
`endif

    always_ff @(posedge clk_10mhz or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            drp_den   <= 1'b0;
            drp_dwe   <= 1'b0;
            drp_daddr <= '0;
            drp_di    <= '0;
            mmcm_rst  <= 1'b1;
            pending   <= 1'b0;
            drp_tmr   <= '0;
            lock_tmr  <= '0;
            high_q    <= '0;
            low_q     <= '0;
            edge_q    <= 1'b0;
            nocnt_q   <= 1'b0;
`ifdef MMCM_DRP_VERIFY_EN
            wr1_q     <= '0;
            wr2_q     <= '0;
`endif
        end else begin
            drp_den <= 1'b0;
            drp_dwe <= 1'b0;
            done    <= 1'b0;
            if (ack) pending <= 1'b0;
            if (pending && drp_tmr != DrpMax) drp_tmr <= drp_tmr + 1'b1;

            if (drp_tmo) begin
                pending  <= 1'b0;
                busy     <= 1'b0;
                err      <= 1'b1;
                mmcm_rst <= 1'b0;
                state    <= StIdle;
            end else begin
                unique case (state)
                    StIdle: begin
                        mmcm_rst <= 1'b0;
                        if (req) begin
                            if (div_ok) begin
                                busy     <= 1'b1;
                                err      <= 1'b0;
                                mmcm_rst <= 1'b1;
                                high_q   <= divide[6:1];
                                low_q    <= low_val;
                                edge_q   <= divide[0];
                                nocnt_q  <= (divide == 7'd1);
                                state    <= StRstOn;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    StRstOn: begin
                        drp_den   <= 1'b1;
                        drp_daddr <= REG1_ADDR;
                        drp_di    <= '0;
                        pending   <= 1'b1;
                        drp_tmr   <= '0;
                        state     <= StRd1;
                    end
                    StRd1: if (ack) begin
                        drp_den   <= 1'b1;
                        drp_dwe   <= 1'b1;
                        drp_daddr <= REG1_ADDR;
                        drp_di    <= wr1_data;
                        pending   <= 1'b1;
                        drp_tmr   <= '0;
`ifdef MMCM_DRP_VERIFY_EN
                        wr1_q     <= wr1_data;
`endif
                        state     <= StWr1;
                    end
                    StWr1: if (ack) begin
                        drp_den   <= 1'b1;
                        drp_daddr <= REG2_ADDR;
                        drp_di    <= '0;
                        pending   <= 1'b1;
                        drp_tmr   <= '0;
                        state     <= StRd2;
                    end
                    StRd2: if (ack) begin
                        drp_den   <= 1'b1;
                        drp_dwe   <= 1'b1;
                        drp_daddr <= REG2_ADDR;
                        drp_di    <= wr2_data;
                        pending   <= 1'b1;
                        drp_tmr   <= '0;
`ifdef MMCM_DRP_VERIFY_EN
                        wr2_q     <= wr2_data;
`endif
                        state     <= StWr2;
                    end
`ifdef MMCM_DRP_VERIFY_EN
                    StWr2: if (ack) begin
                        drp_den   <= 1'b1;
                        drp_daddr <= REG1_ADDR;
                        drp_di    <= '0;
                        pending   <= 1'b1;
                        drp_tmr   <= '0;
                        state     <= StVrf1;
                    end
                    StVrf1: if (ack) begin
                        if (drp_do != wr1_q) begin
                            busy     <= 1'b0;
                            err      <= 1'b1;
                            mmcm_rst <= 1'b0;
                            state    <= StIdle;
                        end else begin
                            drp_den   <= 1'b1;
                            drp_daddr <= REG2_ADDR;
                            pending   <= 1'b1;
                            drp_tmr   <= '0;
                            state     <= StVrf2;
                        end
                    end
                    StVrf2: if (ack) begin
                        busy     <= (drp_do == wr2_q);
                        err      <= (drp_do != wr2_q);
                        mmcm_rst <= 1'b0;
                        state    <= (drp_do == wr2_q) ? StRstOff : StIdle;
                    end
`else
                    StWr2: if (ack) begin
                        mmcm_rst <= 1'b0;
                        state    <= StRstOff;
                    end
`endif
                    StRstOff: begin
                        lock_tmr <= '0;
                        state    <= StWaitLock;
                    end
                    StWaitLock: begin
                        if (mmcm_locked) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= StIdle;
                        end else if (lock_tmr == LockLast) begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            state <= StIdle;
                        end else if (lock_tmr != LockMax) begin
                            lock_tmr <= lock_tmr + 1'b1;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mmcm_drp_ctrl.sv
// Scoreboard bench for mmcm_drp_ctrl: DRP slave and MMCM lock models, expected DRP writes and
// completion events queued by the stimulus and consumed by an independent monitor.
module tb_mmcm_drp_ctrl;

    localparam int unsigned LockTo = 300;
    localparam int unsigned DrpTo  = 16;
    localparam logic [6:0]  R1     = 7'h08;
    localparam logic [6:0]  R2     = 7'h09;
    localparam int          KWrite = 0;
    localparam int          KDone  = 1;
    localparam int          KErr   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [6:0]  divide;
    logic        busy, done, err;
    logic [6:0]  drp_daddr;
    logic        drp_den, drp_dwe;
    logic [15:0] drp_di;
    logic [15:0] drp_do;
    logic        drp_drdy;
    logic        mmcm_rst;
    logic        mmcm_locked;

    always #5 clk = ~clk;

    mmcm_drp_ctrl #(
        .LOCK_TIMEOUT(LockTo),
        .DRP_TIMEOUT (DrpTo)
    ) dut (
        .clk_10mhz  (clk),
        .rst        (rst),
        .req        (req),
        .divide     (divide),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .drp_daddr  (drp_daddr),
        .drp_den    (drp_den),
        .drp_dwe    (drp_dwe),
        .drp_di     (drp_di),
        .drp_do     (drp_do),
        .drp_drdy   (drp_drdy),
        .mmcm_rst   (mmcm_rst),
        .mmcm_locked(mmcm_locked)
    );

    typedef struct {
        int          kind;
        logic [6:0]  addr;
        logic [15:0] data;
        bit          chk_lat;
    } exp_t;

    exp_t        expq[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          last_den = 0;
    logic        err_prev = 1'b0;
    logic [15:0] mem[128];
    logic [15:0] m_r1, m_r2;
    bit          withhold  = 1'b0;
    bit          corrupt   = 1'b0;
    bit          lock_hold = 1'b0;
    int          lock_delay = 20;
    int          sl_delay   = 0;
    bit          sl_pend    = 1'b0;
    logic [15:0] sl_rdata   = '0;
    int          lk_cnt     = 0;
    int          n;
    logic [6:0]  d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic push(input int kind, input logic [6:0] a, input logic [15:0] v, input bit lat);
        exp_t e;
        e.kind = kind; e.addr = a; e.data = v; e.chk_lat = lat;
        expq.push_back(e);
    endtask

    task automatic take(input string name, input int kind, output exp_t e, output bit got);
        e = '{kind: 0, addr: '0, data: '0, chk_lat: 1'b0};
        got = 1'b0;
        n_checks++;
        if (expq.size() == 0) begin
            $display("FAIL %s: got unexpected event, expected none", name);
        end else begin
            e = expq.pop_front();
            if (e.kind == kind) begin
                n_pass++;
                got = 1'b1;
            end else begin
                $display("FAIL %s: got event kind %0d, expected kind %0d", name, kind, e.kind);
            end
        end
    endtask

    // Reference model: divider fields from plain arithmetic on the requested divide.
    function automatic logic [15:0] exp_reg1(input logic [15:0] old, input logic [6:0] dd);
        int dv, hi, lo;
        dv = int'(dd);
        hi = dv / 2;
        lo = dv - hi;
        return (old & 16'hF000) | 16'(hi * 64) | 16'(lo);
    endfunction

    function automatic logic [15:0] exp_reg2(input logic [15:0] old, input logic [6:0] dd);
        int dv;
        dv = int'(dd);
        return (old & 16'hFF3F) | 16'((dv % 2) * 128) | 16'((dv == 1) ? 64 : 0);
    endfunction

    task automatic push_model_writes(input logic [6:0] dd);
        m_r1 = exp_reg1(m_r1, dd);
        m_r2 = exp_reg2(m_r2, dd);
        push(KWrite, R1, m_r1, 1'b0);
        push(KWrite, R2, m_r2, 1'b0);
    endtask

    task automatic issue(input logic [6:0] dd);
        @(negedge clk);
        req = 1'b1;
        divide = dd;
        @(negedge clk);
        req = 1'b0;
        divide = 7'($urandom);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check({name, "_completes"}, 32'(busy), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_den"}, 32'(drp_den), 0);
        check({tag, "_dwe"}, 32'(drp_dwe), 0);
        check({tag, "_daddr"}, 32'(drp_daddr), 0);
        check({tag, "_di"}, 32'(drp_di), 0);
        check({tag, "_mmcm_rst"}, 32'(mmcm_rst), 1);
    endtask

    // DRP slave: 1..4 cycle acknowledge latency, optional withholding, corruption, stray drdy.
    initial begin
        drp_drdy = 1'b0;
        drp_do   = '0;
        forever begin
            @(negedge clk);
            drp_drdy = 1'b0;
            if (rst) begin
                sl_pend = 1'b0;
                continue;
            end
            if (sl_pend) begin
                sl_delay--;
                if (sl_delay == 0) begin
                    drp_drdy = 1'b1;
                    drp_do   = sl_rdata;
                    sl_pend  = 1'b0;
                end
            end else if (drp_den) begin
                if (!withhold) begin
                    sl_pend  = 1'b1;
                    sl_delay = int'($urandom_range(1, 4));
                    if (drp_dwe) begin
                        mem[drp_daddr] = drp_di;
                        sl_rdata = 16'($urandom);
                    end else begin
                        sl_rdata = mem[drp_daddr];
                        if (corrupt && drp_daddr == R1) sl_rdata[0] = ~sl_rdata[0];
                    end
                end
            end else if (!withhold && $urandom_range(0, 7) == 0) begin
                drp_drdy = 1'b1;
                drp_do   = 16'($urandom);
            end
        end
    end

    // MMCM model: LOCKED rises lock_delay cycles after reset release.
    initial begin
        mmcm_locked = 1'b0;
        forever begin
            @(negedge clk);
            if (mmcm_rst || lock_hold) begin
                mmcm_locked = 1'b0;
                lk_cnt = 0;
            end else if (lk_cnt < lock_delay) begin
                lk_cnt++;
            end else begin
                mmcm_locked = 1'b1;
            end
        end
    end

    // Monitor: consumes expectations whenever the DUT writes, completes or flags an error.
    initial begin
        exp_t e;
        bit   got;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                err_prev = 1'b0;
                continue;
            end
            if (drp_den) begin
                last_den = cyc;
                check("den_only_when_busy", 32'(busy), 1);
                if (drp_dwe) begin
                    take("drp_write", KWrite, e, got);
                    if (got) begin
                        check("write_addr", 32'(drp_daddr), 32'(e.addr));
                        check("write_data", 32'(drp_di), 32'(e.data));
                        check("mmcm_rst_during_write", 32'(mmcm_rst), 1);
                    end
                end
            end
            if (done) begin
                take("done", KDone, e, got);
                if (got) begin
                    check("done_busy", 32'(busy), 0);
                    check("done_err", 32'(err), 0);
                    check("done_mmcm_rst", 32'(mmcm_rst), 0);
                end
            end
            if (err && !err_prev) begin
                take("err", KErr, e, got);
                if (got) begin
                    check("err_busy", 32'(busy), 0);
                    check("err_mmcm_rst", 32'(mmcm_rst), 0);
                    if (e.chk_lat) check("drp_timeout_latency", 32'(cyc - last_den), DrpTo);
                end
            end
            err_prev = err;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        req = 1'b0;
        divide = '0;
        for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);
        check("mmcm_rst_release", 32'(mmcm_rst), 0);
        repeat (5) @(negedge clk);

        // Reference case: divide 60 with known register contents, stray req while busy.
        mem[R1] = 16'hF000; mem[R2] = 16'h0300;
        m_r1 = 16'hF79E;    m_r2 = 16'h0300;
        push(KWrite, R1, 16'hF79E, 1'b0);
        push(KWrite, R2, 16'h0300, 1'b0);
        push(KDone, '0, '0, 1'b0);
        lock_delay = 100;
        issue(7'd60);
        check("accept_busy", 32'(busy), 1);
        check("accept_mmcm_rst", 32'(mmcm_rst), 1);
        repeat (4) @(negedge clk);
        issue(7'd5);
        wait_idle("div60");

        // Illegal divides: error without any activity.
        push(KErr, '0, '0, 1'b0);
        issue(7'd127);
        check("div127_busy", 32'(busy), 0);
        check("div127_err", 32'(err), 1);
        repeat (5) @(negedge clk);
        issue(7'd0);
        check("div0_busy", 32'(busy), 0);
        check("div0_err", 32'(err), 1);
        repeat (5) @(negedge clk);

        // divide 7: accepted req clears the sticky error.
        mem[R1] = 16'hA000; mem[R2] = 16'h0000;
        m_r1 = 16'hA0C4;    m_r2 = 16'h0080;
        push(KWrite, R1, 16'hA0C4, 1'b0);
        push(KWrite, R2, 16'h0080, 1'b0);
        push(KDone, '0, '0, 1'b0);
        lock_delay = 30;
        issue(7'd7);
        check("div7_err_cleared", 32'(err), 0);
        check("div7_busy", 32'(busy), 1);
        wait_idle("div7");

        // divide 1: no_count and edge both set.
        mem[R1] = 16'h5000; mem[R2] = 16'h0000;
        m_r1 = 16'h5001;    m_r2 = 16'h00C0;
        push(KWrite, R1, 16'h5001, 1'b0);
        push(KWrite, R2, 16'h00C0, 1'b0);
        push(KDone, '0, '0, 1'b0);
        issue(7'd1);
        wait_idle("div1");

        // Randomized divides against the reference model.
        mem[R1] = 16'($urandom); mem[R2] = 16'($urandom);
        m_r1 = mem[R1]; m_r2 = mem[R2];
        for (int t = 0; t < 6; t++) begin
            d = 7'($urandom_range(1, 126));
            lock_delay = int'($urandom_range(5, 60));
            push_model_writes(d);
            push(KDone, '0, '0, 1'b0);
            issue(d);
            wait_idle("random");
        end

        // DRP acknowledge withheld: timeout on the first access.
        withhold = 1'b1;
        push(KErr, '0, '0, 1'b1);
        issue(7'($urandom_range(1, 126)));
        wait_idle("drp_timeout");
        check("drp_timeout_mmcm_rst", 32'(mmcm_rst), 0);
        withhold = 1'b0;

        // LOCKED never returns: lock timeout after both writes.
        lock_hold = 1'b1;
        d = 7'($urandom_range(1, 126));
        push_model_writes(d);
        push(KErr, '0, '0, 1'b0);
        issue(d);
        wait_idle("lock_timeout");
        lock_hold = 1'b0;

        // Reset while the REG2 read is in flight: only the REG1 write happens.
        d = 7'($urandom_range(1, 126));
        m_r1 = exp_reg1(m_r1, d);
        push(KWrite, R1, m_r1, 1'b0);
        issue(d);
        n = 0;
        while (!(drp_den && !drp_dwe && drp_daddr == R2) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("reach_rd2", 32'(n < 500), 1);
        #1 rst = 1'b1;
        #1 check_reset_vals("mid_rst");
        repeat (2) @(negedge clk);
        check("mmcm_rst_held_in_rst", 32'(mmcm_rst), 1);
        rst = 1'b0;
        @(negedge clk);
        check("mmcm_rst_release2", 32'(mmcm_rst), 0);
        repeat (3) @(negedge clk);
        d = 7'($urandom_range(1, 126));
        push_model_writes(d);
        push(KDone, '0, '0, 1'b0);
        issue(d);
        wait_idle("after_rst");

        // REG1 readback corrupted in bit 0: only caught when readback verification is built in.
        corrupt = 1'b1;
        d = 7'($urandom_range(1, 126));
        push_model_writes(d);
`ifdef MMCM_DRP_VERIFY_EN
        push(KErr, '0, '0, 1'b0);
`else
        push(KDone, '0, '0, 1'b0);
`endif
        issue(d);
        wait_idle("corrupt");
        corrupt = 1'b0;

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(expq.size()), 0);
        check("final_reg1", 32'(mem[R1]), 32'(m_r1));
        check("final_reg2", 32'(mem[R2]), 32'(m_r2));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mmcm_drp_ctrl.md
MMCM_DRP_CTRL -- requirements
Module: mmcm_drp_ctrl

Interface
REQ-001 Parameter LOCK_TIMEOUT, default 1000000: max clk_10mhz cycles waited for mmcm_locked after reset release.
REQ-002 Parameter DRP_TIMEOUT, default 64: max cycles waited for drp_drdy per DRP access.
REQ-003 Parameter REG1_ADDR, default 7'h08: CLKOUT0 ClkReg1 DRP address.
REQ-004 Parameter REG2_ADDR, default 7'h09: CLKOUT0 ClkReg2 DRP address.
REQ-005 clk_10mhz  in  1  single clock; all logic on rising edge. It SHALL NOT be sourced from the MMCM being reconfigured.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 req  in  1  one-cycle request to reprogram CLKOUT0.
REQ-008 divide  in  7  requested CLKOUT0 integer divide; sampled when req is accepted.
REQ-009 busy  out  1  high from req acceptance until done or err.
REQ-010 done  out  1  one-cycle pulse on successful completion.
REQ-011 err  out  1  sticky error flag, cleared by next accepted req.
REQ-012 drp_daddr/drp_den/drp_dwe/drp_di  out  7/1/1/16  DRP master outputs.
REQ-013 drp_do/drp_drdy  in  16/1  DRP read data, access acknowledge.
REQ-014 mmcm_rst  out  1  MMCM reset; mmcm_locked  in  1  MMCM LOCKED.

Function
REQ-015 States: IDLE, RST_ON, RD1, WR1, RD2, WR2, RST_OFF, WAIT_LOCK; one DRP access outstanding at most.
REQ-016 req in IDLE with 1<=divide<=126 SHALL be accepted (busy=1 next cycle); req while busy SHALL be ignored.
REQ-017 req in IDLE with divide 0 or 127 SHALL set err for one state pass: err=1, busy stays 0, no DRP or mmcm_rst activity.
REQ-018 RST_ON: mmcm_rst=1; held through WR2; next state RD1.
REQ-019 Each DRP access: drp_den high exactly one cycle with drp_daddr/drp_dwe/drp_di valid; subsequent state entered on cycle after drp_drdy.
REQ-020 Divider fields: high=floor(divide/2), low=divide-high, edge=divide[0], no_count=(divide==1); 6-bit fields, no overflow in legal range.
REQ-021 RD1 reads REG1_ADDR; WR1 writes {rd[15:12], high[5:0], low[5:0]}.
REQ-022 RD2 reads REG2_ADDR; WR2 writes rd with bit7=edge, bit6=no_count, all other bits preserved.
REQ-023 RST_OFF: mmcm_rst=0; WAIT_LOCK: on mmcm_locked=1 pulse done, return to IDLE.
REQ-024 drp_drdy absent DRP_TIMEOUT cycles after drp_den: set err, drive mmcm_rst=0, return to IDLE, no done.
REQ-025 mmcm_locked absent LOCK_TIMEOUT cycles in WAIT_LOCK: set err, return to IDLE, no done.
REQ-026 drp_drdy arriving while no access is outstanding SHALL be ignored.
REQ-027 Timeout counters SHALL saturate, not wrap; counter width derived from parameter.

Reset
REQ-028 rst asserted (any state, mid-access included): state IDLE, busy=0, done=0, err=0, drp_den=0, drp_dwe=0, drp_daddr=0, drp_di=0, mmcm_rst=1.
REQ-029 mmcm_rst SHALL deassert on first cycle after rst release; DRP access in flight at reset is abandoned.

Configuration
REQ-030 Macro MMCM_DRP_VERIFY_EN defined: after WR2, states VRF1/VRF2 read back REG1_ADDR/REG2_ADDR; mismatch with written value sets err, mmcm_rst=0, return to IDLE without done.
REQ-031 Macro MMCM_DRP_VERIFY_EN undefined: no readback states; WR2 proceeds directly to RST_OFF.

Verification
REQ-032 divide=60, model returns REG1=16'hF000, REG2=16'h0300 -> writes 16'hF79E then 16'h0300; mmcm_rst low after WR2; locked after 100 cycles -> single done, err=0.
REQ-033 divide=7, REG2 read 16'h0000 -> REG1 low bits {high=3,low=4}=0x0C4 (upper nibble preserved), REG2 write 16'h0080.
REQ-034 divide=1 -> REG1 {high=0,low=1}, REG2 write has bit6=1, bit7=1; divide=127 -> err=1, no drp_den.
REQ-035 drp_drdy withheld -> err=1 exactly DRP_TIMEOUT cycles after drp_den, mmcm_rst=0, busy=0, no done.
REQ-036 rst pulsed during RD2 -> all outputs at reset values, mmcm_rst=1 during rst; new req afterwards completes normally.
REQ-037 With MMCM_DRP_VERIFY_EN, model corrupts REG1 readback bit0 -> err=1, no done; without macro same model -> done.
